// File: rtl/mux.sv
// rtl/mux.sv - AHB-Lite slave-to-master response multiplexer (4 slaves, 32-bit data)
module mux (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [1:0]  sel,
    input  logic [31:0] hrdata1,
    input  logic [31:0] hrdata2,
    input  logic [31:0] hrdata3,
    input  logic [31:0] hrdata4,
    input  logic        hreadyout1,
    input  logic        hreadyout2,
    input  logic        hreadyout3,
    input  logic        hreadyout4,
    input  logic        hresp1,
    input  logic        hresp2,
    input  logic        hresp3,
    input  logic        hresp4,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    logic [1:0]  r_sel_q;
    logic [31:0] w_rdata;
    logic        w_ready;
    logic        w_resp;

    always_comb begin
        w_rdata = hrdata1;
        w_ready = hreadyout1;
        w_resp  = hresp1;
        case (r_sel_q)
            2'b00: begin
                w_rdata = hrdata1;
                w_ready = hreadyout1;
                w_resp  = hresp1;
            end
            2'b01: begin
                w_rdata = hrdata2;
                w_ready = hreadyout2;
                w_resp  = hresp2;
            end
            2'b10: begin
                w_rdata = hrdata3;
                w_ready = hreadyout3;
                w_resp  = hresp3;
            end
            2'b11: begin
                w_rdata = hrdata4;
                w_ready = hreadyout4;
                w_resp  = hresp4;
            end
            default: begin
                w_rdata = hrdata1;
                w_ready = hreadyout1;
                w_resp  = hresp1;
            end
        endcase
    end

    // Reset forces an idle OKAY response without waiting for a clock edge.
    assign hrdata    = hreset ? 32'd0 : w_rdata;
    assign hreadyout = hreset ? 1'b1  : w_ready;
    assign hresp     = hreset ? 1'b0  : w_resp;

    // A stalled data phase keeps its slave connected until that slave is ready.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_sel_q <= 2'b00;
        end else if (w_ready) begin
            r_sel_q <= sel;
        end
    end

endmodule

// File: tb/tb_mux.sv
// tb/tb_mux.sv - self-checking bench for mux with an expected-response scoreboard
module tb_mux;

    logic        hclk;
    logic        hreset;
    logic [1:0]  sel;
    logic [31:0] hrdata1, hrdata2, hrdata3, hrdata4;
    logic        hreadyout1, hreadyout2, hreadyout3, hreadyout4;
    logic        hresp1, hresp2, hresp3, hresp4;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    typedef struct {
        string       tag;
        logic [31:0] d;
        logic        r;
        logic        s;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mux dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .sel        (sel),
        .hrdata1    (hrdata1),
        .hrdata2    (hrdata2),
        .hrdata3    (hrdata3),
        .hrdata4    (hrdata4),
        .hreadyout1 (hreadyout1),
        .hreadyout2 (hreadyout2),
        .hreadyout3 (hreadyout3),
        .hreadyout4 (hreadyout4),
        .hresp1     (hresp1),
        .hresp2     (hresp2),
        .hresp3     (hresp3),
        .hresp4     (hresp4),
        .hrdata     (hrdata),
        .hreadyout  (hreadyout),
        .hresp      (hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic push_exp(input string tag, input logic [31:0] d, input logic r, input logic s);
        exp_t e;
        e.tag = tag;
        e.d   = d;
        e.r   = r;
        e.s   = s;
        sb.push_back(e);
    endtask

    task automatic check_next();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=no_entry expected=entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (hrdata === e.d) else begin
            errors++;
            $error("FAIL %s hrdata observed=%h expected=%h", e.tag, hrdata, e.d);
        end
        checks++;
        assert (hreadyout === e.r) else begin
            errors++;
            $error("FAIL %s hreadyout observed=%b expected=%b", e.tag, hreadyout, e.r);
        end
        checks++;
        assert (hresp === e.s) else begin
            errors++;
            $error("FAIL %s hresp observed=%b expected=%b", e.tag, hresp, e.s);
        end
    endtask

    // Push the expectation, let combinational paths settle, then compare.
    task automatic expect_out(input string tag, input logic [31:0] d, input logic r, input logic s);
        push_exp(tag, d, r, s);
        #1;
        check_next();
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hreset     = 1'b0;
        sel        = 2'b10;
        hrdata1    = 32'd1;
        hrdata2    = 32'd2;
        hrdata3    = 32'd3;
        hrdata4    = 32'd4;
        hreadyout1 = 1'b1;
        hreadyout2 = 1'b0;
        hreadyout3 = 1'b1;
        hreadyout4 = 1'b0;
        hresp1     = 1'b1;
        hresp2     = 1'b0;
        hresp3     = 1'b0;
        hresp4     = 1'b1;

        // 1. Reset acts with no clock edge, then release loads sel on the first edge
        #1;
        hreset = 1'b1;
        expect_out("rst_async", 32'd0, 1'b1, 1'b0);
        checks++;
        assert (dut.r_sel_q === 2'b00) else begin
            errors++;
            $error("FAIL rst_selq observed=%b expected=00", dut.r_sel_q);
        end
        tick();
        expect_out("rst_held_edge", 32'd0, 1'b1, 1'b0);
        hreset = 1'b0;
        expect_out("rst_release_s1", 32'd1, 1'b1, 1'b1);
        tick();
        expect_out("rst_first_edge", 32'd3, 1'b1, 1'b0);

        // 2. Full sweep with every slave ready
        hreadyout2 = 1'b1;
        hreadyout4 = 1'b1;
        sel = 2'b00; tick(); expect_out("sweep_s1", 32'd1, 1'b1, 1'b1);
        sel = 2'b01; tick(); expect_out("sweep_s2", 32'd2, 1'b1, 1'b0);
        sel = 2'b10; tick(); expect_out("sweep_s3", 32'd3, 1'b1, 1'b0);
        sel = 2'b11; tick(); expect_out("sweep_s4", 32'd4, 1'b1, 1'b1);

        // 3. Stall on slave2 holds the select regardless of sel
        sel = 2'b01; tick();
        hreadyout2 = 1'b0;
        hreadyout4 = 1'b0;
        expect_out("stall_enter", 32'd2, 1'b0, 1'b0);
        sel = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("stall_hold", 32'd2, 1'b0, 1'b0);
        end
        hreadyout2 = 1'b1;
        expect_out("stall_ready_up", 32'd2, 1'b1, 1'b0);
        tick();
        expect_out("stall_release", 32'd3, 1'b1, 1'b0);
        hreadyout2 = 1'b0;

        // 5. sel glitches between edges do not reach the outputs
        sel = 2'b00; expect_out("glitch_00", 32'd3, 1'b1, 1'b0);
        sel = 2'b11; expect_out("glitch_11", 32'd3, 1'b1, 1'b0);
        sel = 2'b01; expect_out("glitch_01", 32'd3, 1'b1, 1'b0);

        // 4. Slave data passes straight through with no edge
        sel = 2'b00; tick();
        expect_out("pass_s1", 32'd1, 1'b1, 1'b1);
        hrdata1 = 32'hDEADBEEF;
        expect_out("pass_deadbeef", 32'hDEADBEEF, 1'b1, 1'b1);
        hrdata1 = 32'd1;
        expect_out("pass_restore", 32'd1, 1'b1, 1'b1);

        // 6. Async reset while stalled on slave4
        sel = 2'b11; tick();
        expect_out("s4_stall", 32'd4, 1'b0, 1'b1);
        sel = 2'b00; tick();
        expect_out("s4_stall_hold", 32'd4, 1'b0, 1'b1);
        #2;
        hreset = 1'b1;
        expect_out("rst_mid_stall", 32'd0, 1'b1, 1'b0);
        checks++;
        assert (dut.r_sel_q === 2'b00) else begin
            errors++;
            $error("FAIL rst_mid_selq observed=%b expected=00", dut.r_sel_q);
        end
        hreset = 1'b0;
        expect_out("rst_mid_release", 32'd1, 1'b1, 1'b1);
        sel = 2'b10; tick();
        expect_out("post_rst_load", 32'd3, 1'b1, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
